// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, NOP encoding, op classes and the
// load-tracking entry used by the memory stage.
package cpu_pkg;

  localparam logic [5:0]  OP_LOAD  = 6'b010000;
  localparam logic [5:0]  OP_STORE = 6'b010001;
  localparam logic [63:0] NOP_INST = {3'b111, 61'b0};

  typedef enum logic [1:0] {
    CLS_PASS  = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } op_class_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rt;
    logic [63:0] inst;
    logic        err;
  } track_entry_t;

  function automatic op_class_e op_class(input logic [5:0] opcode);
    op_class_e cls;
    case (opcode)
      OP_LOAD:  cls = CLS_LOAD;
      OP_STORE: cls = CLS_STORE;
      default:  cls = CLS_PASS;
    endcase
    return cls;
  endfunction

  // Instructions that write a register through writeback; fetch/decode/exec
  // stall exactly this class while memory_used is high.
  function automatic logic is_wb_bound(input logic [5:0] opcode,
                                       input logic u_flag,
                                       input logic l_flag);
    return (op_class(opcode) == CLS_PASS) && (u_flag || l_flag);
  endfunction

endpackage

// File: rtl/load_track.sv
// RD_LAT-deep shift register following each accepted load through the BRAM
// read latency; the tail entry lines up with valid doutb.
module load_track
  import cpu_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         flush,
  input  logic         push,
  input  logic [4:0]   push_rt,
  input  logic [63:0]  push_inst,
  input  logic         push_err,
  output track_entry_t tail,
  output logic         any_valid
);

  track_entry_t stage_r [RD_LAT];

  // Advance entries one stage per cycle; flush discards everything in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) stage_r[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < RD_LAT; i++) stage_r[i] <= '0;
    end else begin
      if (push) begin
        stage_r[0] <= '{valid: 1'b1, rt: push_rt, inst: push_inst, err: push_err};
      end else begin
        stage_r[0] <= '0;
      end
      for (int i = 1; i < RD_LAT; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  // Reduce the stage valid bits.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < RD_LAT; i++) any_valid = any_valid | stage_r[i].valid;
  end

  assign tail = stage_r[RD_LAT-1];

endmodule

// File: rtl/mem_access.sv
// Memory stage: drives the data BRAM, tracks loads across the read latency
// and hands results or pass-through instructions to writeback.
module mem_access
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              interlock,
  input  logic [63:0]       inst,
  input  logic [31:0]       u_tdata,
  input  logic [31:0]       l_tdata,
  input  logic [4:0]        u_rt,
  input  logic [4:0]        l_rt,
  input  logic              u_rt_flag,
  input  logic              l_rt_flag,
  input  logic [31:0]       ea,
  input  logic [31:0]       st_data,
  output logic [ADDR_W-1:0] addra,
  output logic [31:0]       dina,
  output logic              wea,
  output logic [ADDR_W-1:0] addrb,
  input  logic [31:0]       doutb,
  output logic [63:0]       inst_to_the_next,
  output logic [31:0]       u_tdata_to_the_next,
  output logic [31:0]       l_tdata_to_the_next,
  output logic [4:0]        u_rt_to_the_next,
  output logic [4:0]        l_rt_to_the_next,
  output logic              u_rt_flag_to_the_next,
  output logic              l_rt_flag_to_the_next,
  output logic              memory_used,
  output logic              addr_err,
  output logic              proto_err
);

  op_class_e    cls_s;
  logic         addr_bad_s;
  logic         load_acc_s;
  logic         store_acc_s;
  logic         wb_bound_s;
  logic         any_valid_s;
  track_entry_t tail_s;

  logic [63:0]  nxt_inst_s;
  logic [31:0]  nxt_u_tdata_s;
  logic [31:0]  nxt_l_tdata_s;
  logic [4:0]   nxt_u_rt_s;
  logic [4:0]   nxt_l_rt_s;
  logic         nxt_u_flag_s;
  logic         nxt_l_flag_s;
  logic         nxt_addr_err_s;
  logic         nxt_proto_err_s;

  // Decode the incoming instruction and qualify it against reset and flush.
  always_comb begin
    cls_s       = op_class(inst[63:58]);
    addr_bad_s  = (ea >> ADDR_W) != 32'd0;
    load_acc_s  = rstn && !interlock && (cls_s == CLS_LOAD);
    store_acc_s = rstn && !interlock && (cls_s == CLS_STORE);
    wb_bound_s  = is_wb_bound(inst[63:58], u_rt_flag, l_rt_flag);
  end

  // BRAM ports are driven in the accepting cycle; an out-of-range store never writes.
  always_comb begin
    addra       = rstn ? ea[ADDR_W-1:0] : {ADDR_W{1'b0}};
    addrb       = rstn ? ea[ADDR_W-1:0] : {ADDR_W{1'b0}};
    dina        = rstn ? st_data : 32'd0;
    wea         = store_acc_s && !addr_bad_s;
    memory_used = rstn && (load_acc_s || any_valid_s);
  end

  load_track #(.RD_LAT(RD_LAT)) u_load_track (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (interlock),
    .push      (load_acc_s),
    .push_rt   (l_rt),
    .push_inst (inst),
    .push_err  (addr_bad_s),
    .tail      (tail_s),
    .any_valid (any_valid_s)
  );

  // Select what writeback sees next: a returning load wins, anything arriving
  // behind an in-flight load is swallowed as NOP.
  always_comb begin
    nxt_inst_s    = NOP_INST;
    nxt_u_tdata_s = 32'd0;
    nxt_l_tdata_s = 32'd0;
    nxt_u_rt_s    = 5'd0;
    nxt_l_rt_s    = 5'd0;
    nxt_u_flag_s  = 1'b0;
    nxt_l_flag_s  = 1'b0;
    if (interlock) begin
      nxt_inst_s = NOP_INST;
    end else if (tail_s.valid) begin
      nxt_inst_s    = tail_s.inst;
      nxt_l_tdata_s = tail_s.err ? 32'd0 : doutb;
      nxt_l_rt_s    = tail_s.rt;
      nxt_l_flag_s  = !tail_s.err;
    end else if (any_valid_s) begin
      nxt_inst_s = NOP_INST;
    end else begin
      case (cls_s)
        CLS_LOAD: begin
          nxt_inst_s = NOP_INST;
        end
        CLS_STORE: begin
          nxt_inst_s    = inst;
          nxt_u_tdata_s = u_tdata;
          nxt_l_tdata_s = l_tdata;
          nxt_u_rt_s    = u_rt;
          nxt_l_rt_s    = l_rt;
        end
        CLS_PASS: begin
          nxt_inst_s    = inst;
          nxt_u_tdata_s = u_tdata;
          nxt_l_tdata_s = l_tdata;
          nxt_u_rt_s    = u_rt;
          nxt_l_rt_s    = l_rt;
          nxt_u_flag_s  = u_rt_flag;
          nxt_l_flag_s  = l_rt_flag;
        end
        default: begin
          nxt_inst_s = NOP_INST;
        end
      endcase
    end
  end

  // Sticky error detection for accepted instructions.
  always_comb begin
    nxt_addr_err_s  = addr_err  || (!interlock && (cls_s != CLS_PASS) && addr_bad_s);
    nxt_proto_err_s = proto_err || (!interlock && any_valid_s && wb_bound_s);
  end

  // Writeback-facing output and sticky flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inst_to_the_next      <= NOP_INST;
      u_tdata_to_the_next   <= 32'd0;
      l_tdata_to_the_next   <= 32'd0;
      u_rt_to_the_next      <= 5'd0;
      l_rt_to_the_next      <= 5'd0;
      u_rt_flag_to_the_next <= 1'b0;
      l_rt_flag_to_the_next <= 1'b0;
      addr_err              <= 1'b0;
      proto_err             <= 1'b0;
    end else begin
      inst_to_the_next      <= nxt_inst_s;
      u_tdata_to_the_next   <= nxt_u_tdata_s;
      l_tdata_to_the_next   <= nxt_l_tdata_s;
      u_rt_to_the_next      <= nxt_u_rt_s;
      l_rt_to_the_next      <= nxt_l_rt_s;
      u_rt_flag_to_the_next <= nxt_u_flag_s;
      l_rt_flag_to_the_next <= nxt_l_flag_s;
      addr_err              <= nxt_addr_err_s;
      proto_err             <= nxt_proto_err_s;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: BRAM model plus a cycle-stamped scoreboard of
// expected writeback outputs, checked every cycle on the falling edge.
module tb_mem_access;
  import cpu_pkg::*;

  localparam int ADDR_W = 15;
  localparam int RD_LAT = 2;

  logic              clk = 1'b0;
  logic              rstn;
  logic              interlock;
  logic [63:0]       inst;
  logic [31:0]       u_tdata, l_tdata, ea, st_data, dina, doutb;
  logic [4:0]        u_rt, l_rt;
  logic              u_rt_flag, l_rt_flag, wea;
  logic [ADDR_W-1:0] addra, addrb;
  logic [63:0]       inst_nx;
  logic [31:0]       u_tdata_nx, l_tdata_nx;
  logic [4:0]        u_rt_nx, l_rt_nx;
  logic              u_flag_nx, l_flag_nx, memory_used, addr_err, proto_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int          cyc;
    logic [63:0] inst;
    logic [31:0] u_tdata, l_tdata;
    logic [4:0]  u_rt, l_rt;
    logic        u_flag, l_flag;
    bit          chk_u, chk_l, chk_lrt;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .interlock(interlock), .inst(inst),
    .u_tdata(u_tdata), .l_tdata(l_tdata), .u_rt(u_rt), .l_rt(l_rt),
    .u_rt_flag(u_rt_flag), .l_rt_flag(l_rt_flag), .ea(ea), .st_data(st_data),
    .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .doutb(doutb),
    .inst_to_the_next(inst_nx), .u_tdata_to_the_next(u_tdata_nx),
    .l_tdata_to_the_next(l_tdata_nx), .u_rt_to_the_next(u_rt_nx),
    .l_rt_to_the_next(l_rt_nx), .u_rt_flag_to_the_next(u_flag_nx),
    .l_rt_flag_to_the_next(l_flag_nx), .memory_used(memory_used),
    .addr_err(addr_err), .proto_err(proto_err)
  );

  // Data BRAM: write on port A, RD_LAT-cycle registered read on port B.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    rd_pipe[0] <= mem[addrb];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign doutb = rd_pipe[RD_LAT-1];

  // Scoreboard: the front entry is due in its stamped cycle, otherwise writeback must be NOP.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_checks++;
        if (e.cyc != cyc) begin
          n_fail++; $display("FAIL wb_timing: result due cycle %0d seen at cycle %0d", e.cyc, cyc);
        end
        n_checks++;
        if (inst_nx !== e.inst) begin
          n_fail++; $display("FAIL wb_inst @%0d: got %h expected %h", cyc, inst_nx, e.inst);
        end
        n_checks++;
        if (u_flag_nx !== e.u_flag || l_flag_nx !== e.l_flag) begin
          n_fail++; $display("FAIL wb_flags @%0d: got u=%b l=%b expected u=%b l=%b", cyc, u_flag_nx, l_flag_nx, e.u_flag, e.l_flag);
        end
        if (e.chk_l) begin
          n_checks++;
          if (l_tdata_nx !== e.l_tdata) begin
            n_fail++; $display("FAIL wb_l_tdata @%0d: got %h expected %h", cyc, l_tdata_nx, e.l_tdata);
          end
        end
        if (e.chk_lrt) begin
          n_checks++;
          if (l_rt_nx !== e.l_rt) begin
            n_fail++; $display("FAIL wb_l_rt @%0d: got %0d expected %0d", cyc, l_rt_nx, e.l_rt);
          end
        end
        if (e.chk_u) begin
          n_checks++;
          if (u_tdata_nx !== e.u_tdata || u_rt_nx !== e.u_rt) begin
            n_fail++; $display("FAIL wb_upper @%0d: got %h/%0d expected %h/%0d", cyc, u_tdata_nx, u_rt_nx, e.u_tdata, e.u_rt);
          end
        end
      end else begin
        n_checks++;
        if (inst_nx !== NOP_INST || u_flag_nx !== 1'b0 || l_flag_nx !== 1'b0) begin
          n_fail++; $display("FAIL wb_idle @%0d: got inst=%h u=%b l=%b expected NOP with flags 0", cyc, inst_nx, u_flag_nx, l_flag_nx);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    interlock = 1'b0; inst = NOP_INST; u_tdata = 32'd0; l_tdata = 32'd0;
    u_rt = 5'd0; l_rt = 5'd0; u_rt_flag = 1'b0; l_rt_flag = 1'b0;
    ea = 32'd0; st_data = 32'd0;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
    drive_idle();
    inst = {OP_STORE, 26'd0, a}; ea = a; st_data = d;
    u_rt_flag = 1'b1; l_rt_flag = 1'b1;
  endtask

  task automatic drive_load(input logic [31:0] a, input logic [4:0] rt);
    drive_idle();
    inst = {OP_LOAD, 21'd0, rt, a}; ea = a; l_rt = rt;
  endtask

  task automatic push_exp(input int at, input logic [63:0] i,
                          input logic [31:0] ut, input logic [31:0] lt,
                          input logic [4:0] ur, input logic [4:0] lr,
                          input logic uf, input logic lf,
                          input bit cu, input bit cl, input bit clr);
    exp_t e;
    e.cyc = at; e.inst = i; e.u_tdata = ut; e.l_tdata = lt; e.u_rt = ur; e.l_rt = lr;
    e.u_flag = uf; e.l_flag = lf; e.chk_u = cu; e.chk_l = cl; e.chk_lrt = clr;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive_store(32'h5, 32'h1234_5678);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (inst_nx !== NOP_INST || u_flag_nx !== 1'b0 || l_flag_nx !== 1'b0 || u_tdata_nx !== 32'd0 || l_tdata_nx !== 32'd0) begin
      n_fail++; $display("FAIL reset_wb: got inst=%h flags=%b%b expected NOP/0", inst_nx, u_flag_nx, l_flag_nx);
    end
    n_checks++;
    if (memory_used !== 1'b0 || addr_err !== 1'b0 || proto_err !== 1'b0 || wea !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: got mu=%b ae=%b pe=%b wea=%b expected 0000", memory_used, addr_err, proto_err, wea);
    end
    drive_idle();
    rstn = 1'b1;
    mon_en = 1'b1;
    step();
  endtask

  task automatic test_store();
    drive_store(32'h10, 32'hDEAD_BEEF);
    #1;
    n_checks++;
    if (wea !== 1'b1 || addra !== 15'h10 || dina !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL store_port: got wea=%b addra=%h dina=%h expected 1/0010/deadbeef", wea, addra, dina);
    end
    n_checks++;
    if (memory_used !== 1'b0) begin
      n_fail++; $display("FAIL store_mu: got %b expected 0", memory_used);
    end
    push_exp(cyc + 1, inst, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); drive_idle(); step();
  endtask

  task automatic test_pass();
    drive_idle();
    inst = {6'b000001, 58'h123}; u_tdata = 32'hA5A5_0001; l_tdata = 32'h5A5A_0002;
    u_rt = 5'd3; l_rt = 5'd4; u_rt_flag = 1'b1; l_rt_flag = 1'b1;
    push_exp(cyc + 1, inst, u_tdata, l_tdata, u_rt, l_rt, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    inst = {6'b001010, 58'h77}; u_tdata = 32'h0BAD_F00D; l_tdata = 32'h0000_0042;
    u_rt = 5'd31; l_rt = 5'd0; u_rt_flag = 1'b0; l_rt_flag = 1'b1;
    push_exp(cyc + 1, inst, u_tdata, l_tdata, u_rt, l_rt, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(); drive_idle(); step();
  endtask

  task automatic test_load();
    drive_load(32'h10, 5'd5);
    #1;
    n_checks++;
    if (addrb !== 15'h10 || wea !== 1'b0) begin
      n_fail++; $display("FAIL load_port: got addrb=%h wea=%b expected 0010/0", addrb, wea);
    end
    push_exp(cyc + RD_LAT + 1, inst, 32'd0, 32'hDEAD_BEEF, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k <= RD_LAT + 1; k++) begin
      n_checks++;
      if (memory_used !== (k <= RD_LAT)) begin
        n_fail++; $display("FAIL load_mu N+%0d: got %b expected %b", k, memory_used, (k <= RD_LAT));
      end
      step(); drive_idle();
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h1111_1111; vals[1] = 32'h2222_2222; vals[2] = 32'h3333_3333;
    for (int k = 0; k < 3; k++) begin
      drive_store(32'h20 + k, vals[k]);
      push_exp(cyc + 1, inst, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        drive_load(32'h20 + k, 5'(k + 1));
        push_exp(cyc + RD_LAT + 1, inst, 32'd0, vals[k], 5'd0, 5'(k + 1), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      end else begin
        drive_idle();
      end
      #1;
      n_checks++;
      if (memory_used !== (k <= 2 + RD_LAT)) begin
        n_fail++; $display("FAIL b2b_mu N+%0d: got %b expected %b", k, memory_used, (k <= 2 + RD_LAT));
      end
      step();
    end
    drive_idle(); step();
  endtask

  task automatic test_proto();
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++; $display("FAIL proto_pre: got %b expected 0", proto_err);
    end
    drive_load(32'h10, 5'd7);
    push_exp(cyc + RD_LAT + 1, inst, 32'd0, 32'hDEAD_BEEF, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    drive_idle();
    inst = {6'b000010, 58'h9}; u_tdata = 32'h0000_0123; u_rt = 5'd8; u_rt_flag = 1'b1;
    step();
    drive_idle();
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++; $display("FAIL proto_set: got %b expected 1", proto_err);
    end
    repeat (3) step();
  endtask

  task automatic test_addr_err();
    n_checks++;
    if (addr_err !== 1'b0) begin
      n_fail++; $display("FAIL addr_err_pre: got %b expected 0", addr_err);
    end
    drive_load(32'h0001_0010, 5'd9);
    push_exp(cyc + RD_LAT + 1, inst, 32'd0, 32'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(); drive_idle();
    n_checks++;
    if (addr_err !== 1'b1) begin
      n_fail++; $display("FAIL addr_err_load: got %b expected 1", addr_err);
    end
    repeat (3) step();
    drive_store(32'h0001_0000, 32'hCAFE_F00D);
    #1;
    n_checks++;
    if (wea !== 1'b0) begin
      n_fail++; $display("FAIL addr_err_wea: got %b expected 0", wea);
    end
    push_exp(cyc + 1, inst, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); drive_idle(); step();
    n_checks++;
    if (mem[0] !== 32'd0) begin
      n_fail++; $display("FAIL addr_err_mem: got %h expected 00000000", mem[0]);
    end
  endtask

  task automatic test_interlock();
    drive_load(32'h10, 5'd4);
    step();
    drive_store(32'h30, 32'h0000_0077);
    interlock = 1'b1;
    #1;
    n_checks++;
    if (wea !== 1'b0) begin
      n_fail++; $display("FAIL ilock_wea: got %b expected 0", wea);
    end
    step();
    drive_idle();
    n_checks++;
    if (memory_used !== 1'b0) begin
      n_fail++; $display("FAIL ilock_mu: got %b expected 0", memory_used);
    end
    n_checks++;
    if (proto_err !== 1'b1 || addr_err !== 1'b1) begin
      n_fail++; $display("FAIL ilock_sticky: got pe=%b ae=%b expected 1/1", proto_err, addr_err);
    end
    repeat (3) step();
    n_checks++;
    if (mem[32'h30] !== 32'd0) begin
      n_fail++; $display("FAIL ilock_mem: got %h expected 00000000", mem[32'h30]);
    end
  endtask

  task automatic test_reset_mid();
    drive_load(32'h10, 5'd6);
    step();
    drive_idle();
    #2;
    mon_en = 1'b0;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (memory_used !== 1'b0 || proto_err !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_ctl: got mu=%b pe=%b ae=%b expected 000", memory_used, proto_err, addr_err);
    end
    n_checks++;
    if (inst_nx !== NOP_INST || l_flag_nx !== 1'b0 || l_tdata_nx !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_wb: got inst=%h lf=%b lt=%h expected NOP/0/0", inst_nx, l_flag_nx, l_tdata_nx);
    end
    step();
    rstn = 1'b1;
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (memory_used !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_mu +%0d: got %b expected 0", k, memory_used);
      end
      step();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 32'd0;
    drive_idle();
    test_reset();
    test_store();
    test_pass();
    test_load();
    test_back_to_back();
    test_proto();
    test_addr_err();
    test_interlock();
    test_reset_mid();
    repeat (2) step();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory stage between exec and writeback. Drives the data BRAM (store on port A, load on port B), tracks in-flight loads across the fixed BRAM read latency, and returns load data to writeback on the lower slot. Non-memory instructions pass through in one registered cycle. Raises `memory_used` so fetch/decode/exec stall writeback-bound instructions while loads are outstanding.

## Interface
- `ADDR_W`, 15, BRAM word-address width
- `RD_LAT`, 2, BRAM port-B read latency in cycles (1..4)

- `clk`  in  1  clock
- `rstn`  in  1  asynchronous active-low reset
- `interlock`  in  1  synchronous flush; pipeline held empty while high
- `inst`  in  64  instruction from exec; opcode `inst[63:58]`
- `u_tdata`, `l_tdata`  in  32 each  exec results, upper/lower slot
- `u_rt`, `l_rt`  in  5 each  destination registers
- `u_rt_flag`, `l_rt_flag`  in  1 each  destination-write enables
- `ea`  in  32  effective word address (Load/Store)
- `st_data`  in  32  store data
- `addra`  out  ADDR_W  port-A address (combinational)
- `dina`  out  32  port-A write data (combinational)
- `wea`  out  1  port-A write enable (combinational)
- `addrb`  out  ADDR_W  port-B address (combinational)
- `doutb`  in  32  port-B read data
- `inst_to_the_next`  out  64  instruction to writeback
- `u_tdata_to_the_next`, `l_tdata_to_the_next`  out  32 each
- `u_rt_to_the_next`, `l_rt_to_the_next`  out  5 each
- `u_rt_flag_to_the_next`, `l_rt_flag_to_the_next`  out  1 each
- `memory_used`  out  1  load accepted this cycle or load in flight
- `addr_err`  out  1  sticky: address out of range
- `proto_err`  out  1  sticky: writeback-bound instruction arrived while a load was in flight

## Operation
- Classify `inst`: Load `010000`, Store `010001`, otherwise pass-through.
- Store: `wea`=1, `addra`=`ea[ADDR_W-1:0]`, `dina`=`st_data` in the same cycle. Next cycle, writeback output carries `inst` with both rt_flags 0.
- Load: `addrb`=`ea[ADDR_W-1:0]` in the same cycle. Push {valid, `l_rt`, `inst`} into an RD_LAT-deep tracking shift register. On exit, register `doutb` into `l_tdata_to_the_next` with `l_rt_to_the_next`=tracked rt, `l_rt_flag_to_the_next`=1, upper flag 0.
- Pass-through: all u_/l_ fields and `inst` registered unchanged.
- Loads may issue back-to-back (one per cycle); returns stay in order.
- Pass-through with either rt_flag set while any tracking bit is valid: drop it (output NOP), set `proto_err`. Stores and rt_flag-free instructions during flight are accepted; outputs remain NOP until the load returns.
- `ea[31:ADDR_W]` nonzero on Load/Store: suppress `wea`, treat a Load as returning 0 with rt_flag 0, set `addr_err`.
- No store-to-load forwarding; RAW through memory depends on BRAM collision behaviour.
- Output slot without a result carries NOP `{3'b111, 61'b0}` with flags 0.

## Timing
- `rstn` low (async): tracking register cleared; all outputs 0 except `inst_to_the_next`=NOP; `addr_err`, `proto_err` cleared.
- `interlock` high: tracking register cleared at the clock edge, outputs NOP, `wea`=0; in-flight loads discarded. Sticky flags are unaffected.
- Load accepted in cycle N: `memory_used` high in cycles N..N+RD_LAT; `doutb` sampled at the end of N+RD_LAT-1+1 (valid in N+RD_LAT); result visible in N+RD_LAT+1.
- Pass-through accepted in N: visible in N+1.
- Store in N: BRAM written at the end of N.
- `rstn` deassertion mid-operation: first edge after release starts from empty.

## Structure
- Shared `cpu_pkg`: opcode constants `OP_LOAD`, `OP_STORE`, `NOP_INST`, and the op-class function `is_wb_bound`. `cpu_pkg` already carries the fde_stall class list, so that list and `is_wb_bound` share one definition.
- Sub-module `load_track`: parameterised RD_LAT shift register of {valid, rt, inst, err}, with an `any_valid` output.

## Test plan
- Store `ea`=0x10, `st_data`=0xDEADBEEF -> same cycle `wea`=1, `addra`=0x10, `dina`=0xDEADBEEF; next cycle both flags 0.
- Load `ea`=0x10, `l_rt`=5 at N with BRAM model returning 0xDEADBEEF -> N+3 `l_tdata_to_the_next`=0xDEADBEEF, `l_rt`=5, flag 1; `memory_used` high N..N+2.
- Loads at N, N+1, N+2 to rt 1/2/3 -> results at N+3/N+4/N+5 in order; `memory_used` continuous N..N+4.
- Add (`u_rt_flag`=1) at N+1 after load at N -> dropped, `proto_err`=1, load result unaffected.
- Load with `ea`=0x0001_0000 -> `addr_err`=1, result flag 0 at N+3.
- Load at N, `interlock` high in N+1 -> no result; `memory_used` low from N+2. Async `rstn` pulse mid-flight -> all outputs reset immediately.
